rotate_seq_ctrl: RTL and testbench
==================================

// Module: rotate_seq_ctrl
// PURPOSE
//  Command-driven sequencer for a DW-bit rotate register. Accepts {pattern, step count} over a valid/ready
//  command port, loads the pattern, then rotates it by one position per clock for the requested number of steps.
//  Returns the final pattern over a valid/ready result port.
//  Sits between a software/config master and the rotate datapath. Owns that datapath's load/en sequencing.
// PARAMETERS
//  DW  4  datapath width (bits), >=2
//  CW  8  step-count width; max steps per command = 2**CW-1
// PORTS
//  clk        in   1   single clock, rising edge
//  rst_n      in   1   one clock; reset is asynchronous and active-low
//  cmd_valid  in   1   command present
//  cmd_ready  out  1   controller can accept a command (IDLE only)
//  cmd_data   in   DW  pattern to load
//  cmd_cnt    in   CW  number of single-bit rotate steps
//  res_valid  out  1   result present (DONE only)
//  res_ready  in   1   consumer accepts result
//  res_data   out  DW  rotated pattern (datapath q)
//  busy       out  1   high in LOAD/ROT/DONE
// BEHAVIOUR
//  Reset (rst_n=0, any time, incl. mid-operation): state=IDLE, q=0, remaining=0, cmd_ready=1, res_valid=0, busy=0.
//  FSM states and transitions:
//   IDLE: cmd_ready=1. cmd_valid&cmd_ready at edge -> capture cmd_data, cmd_cnt -> LOAD.
//   LOAD: datapath load=1. Next edge: q<=cmd_data, remaining<=cnt. cnt==0 -> DONE, else -> ROT.
//   ROT:  datapath en=1, load=0. Each edge: q<=rotl(q,1), remaining-=1. remaining==1 at edge -> DONE.
//   DONE: res_valid=1, res_data=q, held stable until res_ready. res_valid&res_ready at edge -> IDLE.
//  Latency: res_valid rises cnt+1 edges after the accepting edge (cnt=0 -> 1 edge; cnt=5 -> 6 edges).
//  No command overlap: cmd_ready=0 from LOAD through the DONE handshake edge. Earliest next accept is the cycle after.
//  Steps are literal: cnt>=DW wraps naturally (cnt=DW returns the original pattern). No modulo shortcut.
//  res_data is valid only while res_valid=1. Outside that window it shows live q.
//  Datapath load and en are never both high. q holds when both are low.
//  cmd_data/cmd_cnt are sampled only at the accept edge. Later changes are ignored.
// CONFIGURATION
//  Macro ROT_BIDIR_EN:
//   defined   -> extra port cmd_dir (in, 1), captured with the command. 0=rotate left, 1=rotate right (q<=rotr(q,1)).
//                The datapath gets a dir input. Timing is identical for both directions.
//   undefined -> no cmd_dir port. Left rotate only. The datapath has no dir logic.
// STRUCTURE
//  Package rot_ctrl_pkg: state encodings ST_IDLE=2'd0, ST_LOAD=2'd1, ST_ROT=2'd2, ST_DONE=2'd3.
//   Also holds the dir encodings DIR_LEFT=1'b0, DIR_RIGHT=1'b1.
//  Sub-module rotate_dp_reg #(DW): per-bit async-reset flops with load/en(/dir) mux, output q.
//  Top level holds the FSM, captured cnt/dir, the remaining down-counter and handshake outputs.
// TESTING (DW=4, CW=8)
//  1. Reset, cmd 4'b0011 cnt=1 -> res_valid 2 edges after accept, res_data=4'b0110. cmd_ready=0 until the res handshake.
//  2. cmd 4'b1001 cnt=0 -> res_valid 1 edge after accept, res_data=4'b1001.
//  3. cmd 4'b1000 cnt=5 -> res_valid after 6 edges, res_data=4'b0001. cnt=4 on 4'b1010 -> 4'b1010.
//  4. Backpressure: hold res_ready=0 for 3 cycles in DONE. res_valid and res_data stay stable, no new accept.
//     Then res_ready=1 -> IDLE, and back-to-back cmd 4'b0101 cnt=2 -> 4'b0101.
//  5. Assert rst_n=0 mid-ROT (cmd 4'b0001 cnt=200, after 10 steps) -> q=0, res_valid=0, cmd_ready=1 at once.
//     After release, a new command completes normally.
//  6. ROT_BIDIR_EN: cmd 4'b0001 cnt=1 dir=1 -> 4'b1000. cmd 4'b0001 cnt=3 dir=0 -> 4'b1000.

Source files
------------

// File: rtl/rot_ctrl_pkg.sv
// Shared encodings for the rotate sequencer: FSM states and rotate direction.
package rot_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_ROT  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/rotate_dp_reg.sv
// Rotate datapath register: per-bit async-reset flops with a load/rotate mux.
// ROT_BIDIR_EN adds a dir input selecting right rotation.
module rotate_dp_reg
    import rot_ctrl_pkg::*;
#(
    parameter int unsigned DW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic          en,
`ifdef ROT_BIDIR_EN
    input  logic          dir,
`endif
    input  logic [DW-1:0] d,
    output logic [DW-1:0] q
);

    for (genvar i = 0; i < DW; i++) begin : g_bit
        localparam int unsigned LSrc = (i == 0) ? DW - 1 : i - 1;
`ifdef ROT_BIDIR_EN
        localparam int unsigned RSrc = (i == DW - 1) ? 0 : i + 1;
`endif
        logic bit_d;

        // load wins over en; the controller never raises both anyway
        always_comb begin
            bit_d = q[i];
            if (load) begin
                bit_d = d[i];
            end else if (en) begin
`ifdef ROT_BIDIR_EN
                bit_d = (dir == DIR_RIGHT) ? q[RSrc] : q[LSrc];
`else
                bit_d = q[LSrc];
`endif
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                q[i] <= 1'b0;
            end else begin
                q[i] <= bit_d;
            end
        end
    end

endmodule

// File: rtl/rotate_seq_ctrl.sv
// Command-driven sequencer: load a pattern, rotate it cnt single steps, return it.
// Optional macro ROT_BIDIR_EN adds a cmd_dir port for right rotation.
module rotate_seq_ctrl
    import rot_ctrl_pkg::*;
#(
    parameter int unsigned DW = 4,
    parameter int unsigned CW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [DW-1:0] cmd_data,
    input  logic [CW-1:0] cmd_cnt,
`ifdef ROT_BIDIR_EN
    input  logic          cmd_dir,
`endif
    output logic          res_valid,
    input  logic          res_ready,
    output logic [DW-1:0] res_data,
    output logic          busy
);

    state_e        state_q, state_d;
    logic [DW-1:0] data_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] remaining_q, remaining_d;
    logic          dp_load, dp_en;
    logic          accept;
`ifdef ROT_BIDIR_EN
    logic          dir_q;
`endif

    assign accept = cmd_valid && cmd_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            remaining_q <= '0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
        end
    end

    // Command fields are sampled only on the accept edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
            cnt_q  <= '0;
`ifdef ROT_BIDIR_EN
            dir_q  <= DIR_LEFT;
`endif
        end else if (accept) begin
            data_q <= cmd_data;
            cnt_q  <= cmd_cnt;
`ifdef ROT_BIDIR_EN
            dir_q  <= cmd_dir;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                remaining_d = cnt_q;
                state_d     = (cnt_q == '0) ? ST_DONE : ST_ROT;
            end
            ST_ROT: begin
                remaining_d = remaining_q - 1'b1;
                if (remaining_q == CW'(1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (res_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = 1'b0;
        res_valid = 1'b0;
        dp_load   = 1'b0;
        dp_en     = 1'b0;
        busy      = 1'b1;
        unique case (state_q)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
            end
            ST_LOAD: dp_load   = 1'b1;
            ST_ROT:  dp_en     = 1'b1;
            ST_DONE: res_valid = 1'b1;
            default: busy      = 1'b0;
        endcase
    end

    rotate_dp_reg #(
        .DW (DW)
    ) u_dp (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (dp_load),
        .en    (dp_en),
`ifdef ROT_BIDIR_EN
        .dir   (dir_q),
`endif
        .d     (data_q),
        .q     (res_data)
    );

endmodule

// File: tb/tb_rotate_seq_ctrl.sv
// Scoreboard bench for rotate_seq_ctrl (DW=4, CW=8); covers cmd_dir when ROT_BIDIR_EN is defined.
module tb_rotate_seq_ctrl;

    typedef struct {
        logic [3:0] data;
        int         lat;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_data;
    logic [7:0] cmd_cnt;
`ifdef ROT_BIDIR_EN
    logic       cmd_dir;
`endif
    logic       res_valid;
    logic       res_ready;
    logic [3:0] res_data;
    logic       busy;

    int   checks;
    int   failures;
    exp_t sb[$];

    rotate_seq_ctrl #(
        .DW (4),
        .CW (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_data  (cmd_data),
        .cmd_cnt   (cmd_cnt),
`ifdef ROT_BIDIR_EN
        .cmd_dir   (cmd_dir),
`endif
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] model(input logic [3:0] x, input logic [7:0] cnt,
                                         input logic dir);
        logic [3:0] r;
        r = x;
        for (int i = 0; i < int'(cnt); i++) begin
            r = dir ? {r[0], r[3:1]} : {r[2:0], r[3]};
        end
        return r;
    endfunction

    task automatic do_cmd(input logic [3:0] data, input logic [7:0] cnt, input logic dir,
                          input int hold);
        exp_t e;
        int   edges;
        edges = 0;
        while (!cmd_ready && edges < 600) begin
            @(posedge clk); #1;
            edges++;
        end
        check("cmd_ready_wait", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_data  = data;
        cmd_cnt   = cnt;
`ifdef ROT_BIDIR_EN
        cmd_dir   = dir;
`endif
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cmd_data  = ~data;
        cmd_cnt   = cnt + 8'd3;
`ifdef ROT_BIDIR_EN
        cmd_dir   = ~dir;
`endif
        e.data = model(data, cnt, dir);
        e.lat  = int'(cnt) + 1;
        sb.push_back(e);
        check("ready_low_load", cmd_ready, 0);
        check("busy_load", busy, 1);

        edges = 0;
        while (!res_valid && edges < 600) begin
            @(posedge clk); #1;
            edges++;
        end
        e = sb.pop_front();
        check("res_latency", edges, e.lat);
        check("res_data", res_data, e.data);
        check("ready_low_done", cmd_ready, 0);

        // Offer a competing command while the result is backpressured
        cmd_valid = (hold > 0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("bp_res_valid", res_valid, 1);
            check("bp_res_data", res_data, e.data);
            check("bp_cmd_ready", cmd_ready, 0);
        end
        cmd_valid = 1'b0;

        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        check("hs_res_valid", res_valid, 0);
        check("hs_cmd_ready", cmd_ready, 1);
        check("hs_busy", busy, 0);
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_data  = 4'h0;
        cmd_cnt   = 8'h0;
`ifdef ROT_BIDIR_EN
        cmd_dir   = 1'b0;
`endif
        res_ready = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_res_valid", res_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_q", res_data, 4'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        do_cmd(4'b0011, 8'd1, 1'b0, 0);
        do_cmd(4'b1001, 8'd0, 1'b0, 0);
        do_cmd(4'b1000, 8'd5, 1'b0, 0);
        do_cmd(4'b1010, 8'd4, 1'b0, 0);
        do_cmd(4'b0011, 8'd3, 1'b0, 3);
        do_cmd(4'b0101, 8'd2, 1'b0, 0);
        do_cmd(4'b0001, 8'd255, 1'b0, 0);

        // Reset in the middle of a long rotation
        cmd_valid = 1'b1;
        cmd_data  = 4'b0001;
        cmd_cnt   = 8'd200;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        repeat (11) begin
            @(posedge clk); #1;
        end
        check("mid_rot_busy", busy, 1);
        check("mid_rot_live_q", res_data, model(4'b0001, 8'd10, 1'b0));
        rst_n = 1'b0;
        #1;
        check("async_rst_q", res_data, 4'h0);
        check("async_rst_res_valid", res_valid, 0);
        check("async_rst_cmd_ready", cmd_ready, 1);
        check("async_rst_busy", busy, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        do_cmd(4'b0110, 8'd1, 1'b0, 0);

`ifdef ROT_BIDIR_EN
        do_cmd(4'b0001, 8'd1, 1'b1, 0);
        do_cmd(4'b0001, 8'd3, 1'b0, 0);
        do_cmd(4'b0110, 8'd6, 1'b1, 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
